// File: rtl/alu_pkg.sv
// ALU operation encodings and datapath widths
// shared by the execute stage and the ALU decoder.
package alu_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;
endpackage

// File: rtl/alu_exec_stage_if.sv
// Issue-to-memory bundle for the execute stage.
// master drives operations in, slave is the stage.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ALUControl;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [REGW-1:0] RdE;
  logic            RegWriteE;
  logic            BranchE;
  logic            BneE;
  logic            PredTakenE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCTargetE;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUResultM;
  logic            ZeroM;
  logic            IllegalM;
  logic            RegWriteM;
  logic [REGW-1:0] RdM;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, ALUControl, SrcA, SrcB,
    output RdE, RegWriteE, BranchE, BneE,
    output PredTakenE, PCE, PCTargetE,
    output flush, out_ready,
    input  in_ready, out_valid, ALUResultM,
    input  ZeroM, IllegalM, RegWriteM, RdM,
    input  redirect, redirect_pc
  );

  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB,
    input  RdE, RegWriteE, BranchE, BneE,
    input  PredTakenE, PCE, PCTargetE,
    input  flush, out_ready,
    output in_ready, out_valid, ALUResultM,
    output ZeroM, IllegalM, RegWriteM, RdM,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result, zero flag and
// illegal-opcode detection.
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one-deep output register with
// valid/ready, flush, and branch mispredict redirect.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_exec_stage_if.slave bus
);
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            accept;
  logic            taken;
  logic            mispredict;

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic            regwrite_q;
  logic [REGW-1:0] rd_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  alu_core u_core (
    .a       (bus.SrcA),
    .b       (bus.SrcB),
    .op      (bus.ALUControl),
    .result  (result),
    .zero    (zero),
    .illegal (illegal)
  );

  assign bus.in_ready = !valid_q | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready
                & !bus.flush;

  // equal operands <=> the subtract result is zero
  assign taken = bus.BranchE
               & ((bus.SrcA == bus.SrcB) ^ bus.BneE);
  assign mispredict = bus.BranchE
                    & (taken ^ bus.PredTakenE);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      illegal_q     <= 1'b0;
      regwrite_q    <= 1'b0;
      rd_q          <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept & mispredict;
      if (accept & mispredict)
        redirect_pc_q <= taken ? bus.PCTargetE
                               : bus.PCE + 32'd4;
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q    <= 1'b1;
        result_q   <= result;
        zero_q     <= zero;
        illegal_q  <= illegal;
        regwrite_q <= bus.RegWriteE & !illegal;
        rd_q       <= bus.RdE;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.ALUResultM  = result_q;
  assign bus.ZeroM       = zero_q;
  assign bus.IllegalM    = illegal_q;
  assign bus.RegWriteM   = regwrite_q;
  assign bus.RdM         = rd_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
endmodule
